// File: rtl/regfile_mp_sb_pkg.sv
// Shared register-file constants and width helpers.
// Used by the register file, decode and hazard logic.
package regfile_pkg;

  localparam int XLEN_D    = 32;
  localparam int NREGS_D   = 32;
  localparam int ZERO_ADDR = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int aw_of(input int nregs);
    return clog2(nregs);
  endfunction

  function automatic int cw_of(input int nregs);
    return clog2(nregs + 1);
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Register-file access bundle: read, write, issue, flush.
// master drives addresses/writes/issue; slave returns data/pend/count.
interface regfile_mp_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int NREGS = NREGS_D,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) ();

  localparam int AW = aw_of(NREGS);
  localparam int CW = cw_of(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_pend;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;
  logic [CW-1:0]       pend_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr,
    output wr_data, iss_en, iss_addr,
    output flush,
    input  rd_data, rd_pend, pend_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr,
    input  wr_data, iss_en, iss_addr,
    input  flush,
    output rd_data, rd_pend, pend_cnt
  );

endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Pending-bit scoreboard: issue sets, writeback clears, flush wipes.
// Ports: clk, rst, wr_en/wr_addr, iss_*, flush -> p_q, p_nxt, pend_cnt.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_D,
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW = aw_of(NREGS),
  localparam int CW = cw_of(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  output logic [NREGS-1:0]  p_q,
  output logic [NREGS-1:0]  p_nxt,
  output logic [CW-1:0]     pend_cnt
);

  logic [NREGS-1:0] clr;
  logic [CW-1:0]    cnt_nxt;

  // Issue is applied after writeback clears: a newer
  // producer keeps the register pending.
  always_comb begin
    clr = '0;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) clr[wr_addr[w*AW +: AW]] = 1'b1;
    end
    p_nxt = p_q & ~clr;
    if (iss_en) p_nxt[iss_addr] = 1'b1;
    if (flush) p_nxt = '0;
    if (ZERO_REG) p_nxt[ZERO_ADDR] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_nxt = cnt_nxt + CW'(p_nxt[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q      <= '0;
      pend_cnt <= '0;
    end else begin
      p_q      <= p_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write bypass and pending scoreboard.
// Ports: clk, rst, bus (slave: reads, writes, issue, flush, pend_cnt).
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_D,
  parameter int NREGS    = NREGS_D,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_mp_sb_if.slave  bus
);

  localparam int AW = aw_of(NREGS);
  localparam logic [AW-1:0] ZA = AW'(ZERO_ADDR);

  logic [XLEN-1:0]     mem [NREGS];
  logic [NREGS-1:0]    p_q;
  logic [NREGS-1:0]    p_nxt;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rpend;
  logic [AW-1:0]       ra;
  logic [AW-1:0]       wa;
  logic                hit;
  logic [XLEN-1:0]     bd;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .flush    (bus.flush),
    .p_q      (p_q),
    .p_nxt    (p_nxt),
    .pend_cnt (bus.pend_cnt)
  );

  // Ports are visited in ascending order so the
  // highest-index port's assignment lands last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] &&
            !(ZERO_REG &&
              bus.wr_addr[w*AW +: AW] == ZA)) begin
          mem[bus.wr_addr[w*AW +: AW]] <=
            bus.wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    rpend = '0;
    ra    = '0;
    wa    = '0;
    hit   = 1'b0;
    bd    = '0;
    for (int k = 0; k < NRD; k++) begin
      ra  = bus.rd_addr[k*AW +: AW];
      hit = 1'b0;
      bd  = '0;
      for (int w = 0; w < NWR; w++) begin
        wa = bus.wr_addr[w*AW +: AW];
        if (bus.wr_en[w] && wa == ra) begin
          hit = 1'b1;
          bd  = bus.wr_data[w*XLEN +: XLEN];
        end
      end
      if (ZERO_REG && ra == ZA) begin
        rdata[k*XLEN +: XLEN] = '0;
        rpend[k]              = 1'b0;
      end else if (BYPASS && hit) begin
        rdata[k*XLEN +: XLEN] = bd;
        rpend[k]              = p_nxt[ra];
      end else begin
        rdata[k*XLEN +: XLEN] = mem[ra];
        rpend[k]              = p_q[ra];
      end
    end
  end

  assign bus.rd_data = rdata;
  assign bus.rd_pend = rpend;

endmodule
